ahb_errslave: RTL and testbench
===============================

# ahb_errslave

Parametrised AHB-Lite default/error slave. It is selected by the address decoder for unmapped regions. It answers every NONSEQ/SEQ transfer with a configurable number of wait states, followed by either the two-cycle ERROR response or an OKAY completion (RAZ/WI). It also logs the first faulting access and counts faults for software, with an optional interrupt.

## Interface
- ADDR_W, 32, haddr and err_addr width
- CNT_W, 8, fault counter width, saturating
- WAIT_CYCLES, 0, wait states inserted before the response; legal range 0..15
- RESP_MODE, 1, 1 = ERROR response, 0 = OKAY response (reads return 0, writes ignored)
- IRQ_EN, 1, 1 = irq driven from err_valid; 0 = irq tied 0

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset: asynchronous, active-low
- hsel  in  1  slave select from the decoder
- haddr  in  ADDR_W  address-phase address
- htrans  in  2  transfer type
- hwrite  in  1  address-phase direction
- hsize  in  3  address-phase size
- hready  in  1  system-wide HREADY
- hrdata  out  32  read data, constant 0
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- err_valid  out  1  a fault has been logged since the last clear
- err_addr  out  ADDR_W  haddr of the first logged fault
- err_write  out  1  hwrite of the first logged fault
- err_size  out  3  hsize of the first logged fault
- err_count  out  CNT_W  number of faults, saturating
- err_clr  in  1  single-cycle pulse that clears the log
- irq  out  1  fault interrupt, level

## Operation
- req = hsel & htrans[1] & hready, evaluated combinationally in the address-phase cycle.
- IDLE and BUSY transfers (htrans[1]=0) never leave IDLE and always get zero-wait OKAY.

State machine: IDLE, WAIT, ERR1, ERR2.

| State | hreadyout | hresp |
|---|---|---|
| IDLE | 1 | 0 |
| WAIT | 0 | 0 |
| ERR1 | 0 | 1 |
| ERR2 | 1 | 1 |

Transitions:
- IDLE: on req, go to WAIT if WAIT_CYCLES>0. Otherwise go to ERR1 (RESP_MODE=1) or stay in IDLE (RESP_MODE=0, zero-wait OKAY).
- WAIT: a down-counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle. At 0, go to ERR1 (RESP_MODE=1) or IDLE (RESP_MODE=0). The IDLE cycle is the OKAY completion cycle.
- ERR1 always goes to ERR2.
- ERR2: on req (back-to-back transfer not cancelled by the master), start a new sequence exactly as from IDLE. Otherwise go to IDLE.
- Waits counter width is max(1, clog2(WAIT_CYCLES+1)).

Logging, applied on every req in either RESP_MODE:
- If err_valid=0: capture haddr, hwrite and hsize, and set err_valid.
- If err_valid=1: the captured fields hold (first-fault semantics).
- err_count increments by 1 and saturates at 2^CNT_W-1.

err_clr:
- Clears err_valid and err_count.
- Captured fields keep their values.
- If err_clr and req occur in the same cycle, req wins for capture: err_valid=1, new fields captured, err_count=1.

Other outputs:
- irq = err_valid & IRQ_EN.
- hrdata = 0 at all times.

## Timing
- Reset values:
  - State IDLE, so hreadyout=1 and hresp=0.
  - err_valid=0, err_addr=0, err_write=0, err_size=0, err_count=0, irq=0, wait counter 0.
- Reset asserted mid-sequence returns to IDLE asynchronously: hreadyout=1 and hresp=0 immediately, and the log is cleared.
- With req in cycle N and W = WAIT_CYCLES:
  - Cycles N+1 .. N+W: WAIT.
  - RESP_MODE=1: N+W+1 is ERR1, N+W+2 is ERR2.
  - RESP_MODE=0: N+W+1 is the IDLE completion cycle (hreadyout=1, hresp=0). For W=0 the transfer completes in N+1 with no stall.
- Log fields, err_count and irq update at the clock edge ending cycle N and are visible in N+1.
- hresp is never 1 while hreadyout=1 unless the preceding cycle was ERR1.
- All outputs are registered or decoded from registered state, with no combinational path from inputs. Exception: none.

## Test plan
- Reset, then WAIT_CYCLES=0, RESP_MODE=1, single NONSEQ write to 0x4000_0010 with hsize=2. Required: cycles N+1 and N+2 give (hreadyout,hresp) = (0,1) then (1,1), then back to (1,0). Also err_valid=1, err_addr=0x4000_0010, err_write=1, err_size=2, err_count=1, irq=1.
- WAIT_CYCLES=3, RESP_MODE=1, NONSEQ read. Required: 3 cycles of (0,0), then (0,1), then (1,1).
- RESP_MODE=0, WAIT_CYCLES=2, read. Required: 2 cycles of (0,0), then (1,0) with hrdata=0 and err_count=1. Repeat with W=0: zero-wait OKAY.
- htrans=IDLE and BUSY with hsel=1, and NONSEQ with hready=0. Required: no state change, err_count unchanged.
- Back-to-back: a second NONSEQ to 0x8 presented during ERR2. Required: a new ERR1/ERR2 pair, err_addr still holds the first address, err_count=2. With CNT_W=2, 5 faults give err_count=3.
- err_clr alone clears err_valid, err_count and irq. err_clr coincident with a req to 0xC gives err_valid=1, err_addr=0xC, err_count=1. Reset asserted during ERR1 gives hreadyout=1 asynchronously.

Source files
------------

// File: rtl/ahb_errslave.sv
// AHB-Lite default/error slave for unmapped address regions.
// Answers each transfer with optional wait states then ERROR or OKAY, and logs the first fault.
module ahb_errslave #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned RESP_MODE   = 1,
  parameter int unsigned IRQ_EN      = 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_write,
  output logic [2:0]        err_size,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_clr,
  output logic              irq
);

  localparam int unsigned WCW = (WAIT_CYCLES != 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WLOAD = (WAIT_CYCLES != 0) ? WCW'(WAIT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           hreadyout_d, hresp_d;
  logic           req_c;
  logic           unused_c;

  assign req_c    = hsel & htrans[1] & hready;
  assign unused_c = htrans[0];
  assign hrdata   = '0;

  // State, wait counter and registered response decode
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
    end
  end

  // Next state; IDLE and ERR2 both accept a new transfer
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (req_c) begin
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            wcnt_d  = WLOAD;
          end else if (RESP_MODE != 0) begin
            state_d = S_ERR1;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = (RESP_MODE != 0) ? S_ERR1 : S_IDLE;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_WAIT: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b0;
      end
      S_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      S_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
    endcase
  end

  // Fault log: first-fault capture, saturating count; a req beats a coincident clear
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
      err_size  <= '0;
      err_count <= '0;
      irq       <= 1'b0;
    end else begin
      if (req_c) begin
        if (!err_valid || err_clr) begin
          err_addr  <= haddr;
          err_write <= hwrite;
          err_size  <= hsize;
        end
        err_valid <= 1'b1;
        if (err_clr) begin
          err_count <= CNT_W'(1);
        end else if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_W'(1);
        end
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_count <= '0;
      end
      irq <= (IRQ_EN != 0) & (req_c | (err_valid & ~err_clr));
    end
  end

endmodule

// File: tb/tb_ahb_errslave.sv
// Randomized bench for ahb_errslave: four parameter sets share one stimulus stream,
// each compared every cycle against a cycle-count based reference model.
module tb_ahb_errslave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic        err_clr;

  logic        ro[4], rsp[4], ev[4], ew[4], iq[4];
  logic [31:0] rd[4], ea[4];
  logic [2:0]  es[4];
  logic [7:0]  cnt[3];
  logic [1:0]  cnt3;

  int n_chk = 0;
  int n_fail = 0;

  // Model configuration: wait states, error mode, count ceiling, irq enable
  int unsigned mw[4]   = '{0, 3, 2, 0};
  bit          mr[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
  int unsigned mmax[4] = '{255, 255, 255, 3};
  bit          mirq[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // Model state: cycles left in the current response, and the fault log
  int unsigned left[4];
  bit          mv[4];
  logic [31:0] ma[4];
  bit          mwr[4];
  logic [2:0]  msz[4];
  int unsigned mc[4];

  always #5 hclk = ~hclk;

  ahb_errslave #(.ADDR_W(32), .CNT_W(8), .WAIT_CYCLES(0), .RESP_MODE(1), .IRQ_EN(1)) u_d0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hready), .hrdata(rd[0]), .hreadyout(ro[0]),
    .hresp(rsp[0]), .err_valid(ev[0]), .err_addr(ea[0]), .err_write(ew[0]),
    .err_size(es[0]), .err_count(cnt[0]), .err_clr(err_clr), .irq(iq[0]));

  ahb_errslave #(.ADDR_W(32), .CNT_W(8), .WAIT_CYCLES(3), .RESP_MODE(1), .IRQ_EN(1)) u_d1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hready), .hrdata(rd[1]), .hreadyout(ro[1]),
    .hresp(rsp[1]), .err_valid(ev[1]), .err_addr(ea[1]), .err_write(ew[1]),
    .err_size(es[1]), .err_count(cnt[1]), .err_clr(err_clr), .irq(iq[1]));

  ahb_errslave #(.ADDR_W(32), .CNT_W(8), .WAIT_CYCLES(2), .RESP_MODE(0), .IRQ_EN(1)) u_d2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hready), .hrdata(rd[2]), .hreadyout(ro[2]),
    .hresp(rsp[2]), .err_valid(ev[2]), .err_addr(ea[2]), .err_write(ew[2]),
    .err_size(es[2]), .err_count(cnt[2]), .err_clr(err_clr), .irq(iq[2]));

  ahb_errslave #(.ADDR_W(32), .CNT_W(2), .WAIT_CYCLES(0), .RESP_MODE(0), .IRQ_EN(0)) u_d3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hready), .hrdata(rd[3]), .hreadyout(ro[3]),
    .hresp(rsp[3]), .err_valid(ev[3]), .err_addr(ea[3]), .err_write(ew[3]),
    .err_size(es[3]), .err_count(cnt3), .err_clr(err_clr), .irq(iq[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {hreadyout, hresp} from the number of response cycles still to run
  function automatic logic [1:0] mresp(input int i);
    if (left[i] == 0) return 2'b10;
    if (mr[i]) begin
      if (left[i] > 2) return 2'b00;
      if (left[i] == 2) return 2'b01;
      return 2'b11;
    end
    if (left[i] > 1) return 2'b00;
    return 2'b10;
  endfunction

  function automatic logic [31:0] count_of(input int i);
    if (i == 3) return {30'd0, cnt3};
    return {24'd0, cnt[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      mv[i]   = 1'b0;
      ma[i]   = '0;
      mwr[i]  = 1'b0;
      msz[i]  = '0;
      mc[i]   = 0;
    end
  endtask

  task automatic check_all();
    logic [1:0] e;
    for (int i = 0; i < 4; i++) begin
      e = mresp(i);
      check($sformatf("d%0d hreadyout", i), {31'd0, ro[i]}, {31'd0, e[1]});
      check($sformatf("d%0d hresp", i), {31'd0, rsp[i]}, {31'd0, e[0]});
      check($sformatf("d%0d hrdata", i), rd[i], 32'd0);
      check($sformatf("d%0d err_valid", i), {31'd0, ev[i]}, {31'd0, mv[i]});
      check($sformatf("d%0d err_addr", i), ea[i], ma[i]);
      check($sformatf("d%0d err_write", i), {31'd0, ew[i]}, {31'd0, mwr[i]});
      check($sformatf("d%0d err_size", i), {29'd0, es[i]}, {29'd0, msz[i]});
      check($sformatf("d%0d err_count", i), count_of(i), mc[i]);
      check($sformatf("d%0d irq", i), {31'd0, iq[i]}, {31'd0, mv[i] & mirq[i]});
    end
  endtask

  // One bus cycle: drive at the falling edge, advance the model at the rising edge, check
  task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz, input logic rdy, input logic clr);
    bit req;
    bit acc;
    hsel = sel; htrans = tr; haddr = a; hwrite = wr; hsize = sz; hready = rdy; err_clr = clr;
    req = sel & tr[1] & rdy;
    @(posedge hclk);
    for (int i = 0; i < 4; i++) begin
      acc = mresp(i) == 2'b10 || mresp(i) == 2'b11;
      left[i] = (left[i] > 0) ? left[i] - 1 : 0;
      if (req && acc) left[i] = mw[i] + (mr[i] ? 2 : 1);
      if (req) begin
        if (!mv[i] || clr) begin
          ma[i] = a; mwr[i] = wr; msz[i] = sz;
        end
        mv[i] = 1'b1;
        mc[i] = clr ? 1 : ((mc[i] < mmax[i]) ? mc[i] + 1 : mc[i]);
      end else if (clr) begin
        mv[i] = 1'b0;
        mc[i] = 0;
      end
    end
    @(negedge hclk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    hresetn = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = '0;
    hready = 1'b1; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge hclk);
    check_all();
    hresetn = 1'b1;

    // Single NONSEQ write, then a NONSEQ read
    step(1'b1, 2'b10, 32'h4000_0010, 1'b1, 3'd2, 1'b1, 1'b0);
    idle(6);
    step(1'b1, 2'b10, 32'h0000_0100, 1'b0, 3'd2, 1'b1, 1'b0);
    idle(6);

    // Non-transfers: IDLE, BUSY, and NONSEQ while hready is low
    step(1'b1, 2'b00, 32'h0000_0200, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 32'h0000_0204, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 2'b10, 32'h0000_0208, 1'b1, 3'd1, 1'b0, 1'b0);
    idle(2);

    // Back-to-back: second NONSEQ lands while the zero-wait error slave is in ERR2
    step(1'b1, 2'b10, 32'h0000_0004, 1'b0, 3'd2, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 2'b11, 32'h0000_0008, 1'b0, 3'd2, 1'b1, 1'b0);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b10, 32'h0000_0010 + 32'(k), 1'b1, 3'd0, 1'b1, 1'b0);
      idle(6);
    end

    // Clear alone, then clear coincident with a req
    step(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 2'b10, 32'h0000_000C, 1'b0, 3'd2, 1'b1, 1'b1);
    idle(6);

    // Asynchronous reset while the zero-wait error slave is in ERR1
    step(1'b1, 2'b10, 32'h0000_0300, 1'b1, 3'd2, 1'b1, 1'b0);
    hsel = 1'b0; htrans = 2'b00;
    #1 hresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge hclk);
    hresetn = 1'b1;
    idle(1);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom & 32'hFFFF_FFFC,
           1'($urandom), 3'($urandom_range(0, 2)), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
